// File: rtl/fpu_cvt_to_int_pipe.sv
// Two-stage elastic FP-to-integer converter (FCVT.W/WU/L/LU.S/D) with RISC-V rounding,
// saturation and NV/NX flags. S1 classifies and aligns; S2 rounds, range-checks and registers.
module fpu_cvt_to_int_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned INT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [EXP_W+MAN_W:0]     op_a_i,
  input  logic                     unsigned_i,
  input  logic [2:0]               rm_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [INT_W-1:0]         result_o,
  output logic [4:0]               fflags_o,
  output logic [TAG_W-1:0]         tag_o
);

  localparam int unsigned FP_W    = EXP_W + MAN_W + 1;
  localparam int unsigned SH_W    = MAN_W + INT_W + 1;
  localparam int unsigned BIAS    = 2**(EXP_W-1) - 1;
  localparam int unsigned OVF_EXP = BIAS + INT_W + 1;

  localparam logic [INT_W+1:0] LIM_S_POS = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [INT_W+1:0] LIM_S_NEG = {2'b00, 1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W+1:0] LIM_U     = {2'b00, {INT_W{1'b1}}};

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  // Handshake
  logic s1_v, s2_v;
  logic s2_ready, s1_ready, accept, s1_adv;

  assign s2_ready   = !s2_v | out_ready_i;
  assign s1_ready   = !s1_v | s2_ready;
  assign in_ready_o = s1_ready;
  assign accept     = in_valid_i & s1_ready & !flush_i;
  assign s1_adv     = s1_v & s2_ready;

  // S1: classify and align
  logic                 a_sign, a_nan, a_ovf, a_g, a_st;
  logic [EXP_W-1:0]     a_exp;
  logic [MAN_W-1:0]     a_man;
  logic [MAN_W:0]       a_sig;
  logic [SH_W-1:0]      a_shifted;
  logic [INT_W:0]       a_mag;
  int unsigned          a_expu;

  assign a_sign = op_a_i[FP_W-1];
  assign a_exp  = op_a_i[FP_W-2 -: EXP_W];
  assign a_man  = op_a_i[MAN_W-1:0];
  assign a_expu = 32'(a_exp);
  assign a_sig  = {|a_exp, a_man};

  // Only e in [-1, INT_W] needs a real shift; anything smaller is pure sticky.
  always_comb begin
    a_nan     = (&a_exp) & (|a_man);
    a_ovf     = (&a_exp) | (a_expu >= OVF_EXP);
    a_shifted = '0;
    a_mag     = '0;
    a_g       = 1'b0;
    a_st      = 1'b0;
    if (a_ovf) begin
      a_st = 1'b0;
    end else if (a_expu >= BIAS) begin
      a_shifted = {{INT_W{1'b0}}, a_sig} << (a_expu - BIAS);
      a_mag     = a_shifted[SH_W-1:MAN_W];
      a_g       = a_shifted[MAN_W-1];
      a_st      = |a_shifted[MAN_W-2:0];
    end else if (a_expu == BIAS - 1) begin
      a_g  = 1'b1;
      a_st = |a_man;
    end else begin
      a_st = (|a_exp) | (|a_man);
    end
  end

  logic                 s1_sign, s1_nan, s1_ovf, s1_g, s1_st, s1_uns;
  logic [INT_W:0]       s1_mag;
  logic [2:0]           s1_rm;
  logic [TAG_W-1:0]     s1_tag;

  // S2: round, range check, saturate
  logic                 up, in_range, neg_sat;
  logic [INT_W+1:0]     rmag;
  logic [INT_W-1:0]     b_res;
  logic [4:0]           b_flags;

  always_comb begin
    case (rm_e'(s1_rm))
      RM_RNE:  up = s1_g & (s1_st | s1_mag[0]);
      RM_RDN:  up = s1_sign & (s1_g | s1_st);
      RM_RUP:  up = !s1_sign & (s1_g | s1_st);
      RM_RMM:  up = s1_g;
      default: up = 1'b0;
    endcase
    rmag    = {1'b0, s1_mag} + {{(INT_W+1){1'b0}}, up};
    neg_sat = s1_sign & !s1_nan;
    if (s1_nan | s1_ovf)
      in_range = 1'b0;
    else if (s1_uns)
      in_range = s1_sign ? (rmag == '0) : (rmag <= LIM_U);
    else
      in_range = s1_sign ? (rmag <= LIM_S_NEG) : (rmag <= LIM_S_POS);
    b_flags = '0;
    if (in_range) begin
      b_res      = s1_sign ? -rmag[INT_W-1:0] : rmag[INT_W-1:0];
      b_flags[0] = s1_g | s1_st;
    end else begin
      b_flags[4] = 1'b1;
      if (s1_uns)
        b_res = neg_sat ? '0 : '1;
      else
        b_res = neg_sat ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (flush_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= accept | (s1_v & !s2_ready);
      if (s2_ready) s2_v <= s1_v;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_ovf  <= 1'b0;
      s1_g    <= 1'b0;
      s1_st   <= 1'b0;
      s1_uns  <= 1'b0;
      s1_mag  <= '0;
      s1_rm   <= '0;
      s1_tag  <= '0;
    end else if (accept) begin
      s1_sign <= a_sign;
      s1_nan  <= a_nan;
      s1_ovf  <= a_ovf;
      s1_g    <= a_g;
      s1_st   <= a_st;
      s1_uns  <= unsigned_i;
      s1_mag  <= a_mag;
      s1_rm   <= rm_i;
      s1_tag  <= tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      result_o <= '0;
      fflags_o <= '0;
      tag_o    <= '0;
    end else if (s1_adv) begin
      result_o <= b_res;
      fflags_o <= b_flags;
      tag_o    <= s1_tag;
    end
  end

  assign out_valid_o = s2_v;

endmodule

// File: tb/tb_fpu_cvt_to_int_pipe.sv
// Self-checking bench for fpu_cvt_to_int_pipe (single precision to 32-bit): directed cases,
// randomized ops against an arithmetic reference model, streaming with stall, flush and reset.
module tb_fpu_cvt_to_int_pipe;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] op_a_i;
  logic        unsigned_i;
  logic [2:0]  rm_i;
  logic [4:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;
  logic [4:0]  tag_o;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  fpu_cvt_to_int_pipe #(
    .EXP_W(8),
    .MAN_W(23),
    .INT_W(32),
    .TAG_W(5)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .op_a_i     (op_a_i),
    .unsigned_i (unsigned_i),
    .rm_i       (rm_i),
    .tag_i      (tag_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .fflags_o   (fflags_o),
    .tag_o      (tag_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact value = sig * 2^(e-23), rounded by comparing the discarded
  // remainder against one half, then range-checked as a signed 64-bit integer.
  function automatic logic [36:0] model(input logic [31:0] a, input logic u, input logic [2:0] r);
    logic        s;
    int          ex, e, k;
    longint      sig, mag, rem, half, val;
    bit          exact, tie, above, inc, ok;
    logic [31:0] satv;
    s    = a[31];
    ex   = int'(a[30:23]);
    satv = s ? (u ? 32'h0 : 32'h8000_0000) : (u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF);
    if (ex == 255 && a[22:0] != 0) return {5'h10, (u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF)};
    if (ex == 255) return {5'h10, satv};
    sig = (ex == 0) ? longint'(a[22:0]) : longint'({1'b1, a[22:0]});
    e   = (ex == 0) ? -126 : ex - 127;
    if (e >= 40) return {5'h10, satv};
    if (e >= 23) begin
      mag  = sig <<< (e - 23);
      rem  = 0;
      half = 1;
    end else begin
      k = 23 - e;
      if (k >= 62) begin
        mag  = 0;
        rem  = sig;
        half = longint'(1) <<< 61;
      end else begin
        mag  = sig >>> k;
        rem  = sig - (mag <<< k);
        half = longint'(1) <<< (k - 1);
      end
    end
    exact = (rem == 0);
    tie   = (rem == half);
    above = (rem > half);
    case (r)
      3'd0:    inc = above || (tie && (mag % 2 == 1));
      3'd2:    inc = s && !exact;
      3'd3:    inc = !s && !exact;
      3'd4:    inc = above || tie;
      default: inc = 1'b0;
    endcase
    mag = mag + longint'(inc);
    val = s ? -mag : mag;
    if (u) ok = (val >= 0) && (val <= 64'sh0_FFFF_FFFF);
    else   ok = (val >= -(longint'(1) <<< 31)) && (val <= (longint'(1) <<< 31) - 1);
    if (!ok) return {5'h10, satv};
    return {4'b0, !exact, val[31:0]};
  endfunction

  // One isolated op: drive, wait for the result (bounded), check latency and outputs.
  task automatic single(input logic [31:0] a, input logic u, input logic [2:0] r,
                        input logic [4:0] tg, input logic [31:0] exp_res,
                        input logic [4:0] exp_fl, input string name);
    int n;
    @(negedge clk);
    op_a_i = a; unsigned_i = u; rm_i = r; tag_i = tg;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    n = 0;
    @(posedge clk);
    #1;
    while (!out_valid_o && n < 8) begin
      @(posedge clk);
      #1 n++;
    end
    check({name, "_lat"}, 64'(n), 64'd0);
    check({name, "_res"}, 64'(result_o), 64'(exp_res));
    check({name, "_flg"}, 64'(fflags_o), 64'(exp_fl));
    check({name, "_tag"}, 64'(tag_o), 64'(tg));
  endtask

  logic [36:0] m;
  logic [41:0] expq[$];
  logic [31:0] a_r;
  logic        u_r;
  logic [2:0]  r_r;
  int          sent, got, cyc, seen;
  bit          saw_block;

  initial begin
    reset_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    op_a_i = '0; unsigned_i = 1'b0; rm_i = '0; tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_res", 64'(result_o), 64'd0);
    check("rst_flags", 64'(fflags_o), 64'd0);
    check("rst_tag", 64'(tag_o), 64'd0);
    @(negedge clk) reset_i = 1'b1;
    #1 check("rst_ready", 64'(in_ready_o), 64'd1);

    single(32'h3FC00000, 1'b0, 3'd0, 5'd1, 32'd2, 5'h01, "p1_5_rne");
    single(32'h40200000, 1'b0, 3'd0, 5'd2, 32'd2, 5'h01, "p2_5_rne");
    single(32'h40200000, 1'b0, 3'd4, 5'd3, 32'd3, 5'h01, "p2_5_rmm");
    single(32'h40200000, 1'b0, 3'd1, 5'd4, 32'd2, 5'h01, "p2_5_rtz");
    single(32'h3FC00000, 1'b0, 3'd5, 5'd5, 32'd1, 5'h01, "rsvd_rm");
    single(32'hCF000000, 1'b0, 3'd1, 5'd6, 32'h8000_0000, 5'h00, "min_int");
    single(32'h4F000000, 1'b0, 3'd0, 5'd7, 32'h7FFF_FFFF, 5'h10, "p2_31_s");
    single(32'h4F000000, 1'b1, 3'd0, 5'd8, 32'h8000_0000, 5'h00, "p2_31_u");
    single(32'hBF000000, 1'b1, 3'd1, 5'd9, 32'h0, 5'h01, "m0_5_u_rtz");
    single(32'hBF000000, 1'b1, 3'd2, 5'd10, 32'h0, 5'h10, "m0_5_u_rdn");
    single(32'h3F000000, 1'b0, 3'd3, 5'd11, 32'd1, 5'h01, "p0_5_rup");
    single(32'h00000001, 1'b0, 3'd3, 5'd12, 32'd1, 5'h01, "sub_rup");
    single(32'h00000001, 1'b0, 3'd2, 5'd13, 32'd0, 5'h01, "sub_rdn");
    single(32'h7FC00000, 1'b0, 3'd0, 5'd14, 32'h7FFF_FFFF, 5'h10, "nan_s");
    single(32'h7FC00000, 1'b1, 3'd0, 5'd15, 32'hFFFF_FFFF, 5'h10, "nan_u");
    single(32'hFF800000, 1'b1, 3'd0, 5'd16, 32'h0, 5'h10, "ninf_u");
    single(32'hFF800000, 1'b0, 3'd0, 5'd17, 32'h8000_0000, 5'h10, "ninf_s");
    single(32'h80000000, 1'b0, 3'd0, 5'd18, 32'h0, 5'h00, "nzero");

    for (int i = 0; i < 60; i++) begin
      a_r = $urandom;
      case ($urandom % 8)
        0:       a_r[30:23] = 8'd0;
        1:       a_r[30:23] = 8'd255;
        default: a_r[30:23] = 8'(100 + $urandom % 70);
      endcase
      u_r = 1'($urandom % 2);
      r_r = 3'($urandom % 8);
      m   = model(a_r, u_r, r_r);
      single(a_r, u_r, r_r, 5'(i), m[31:0], m[36:32], "rand");
    end

    // Streaming with a 3-cycle consumer stall
    sent = 0; got = 0; cyc = 0; saw_block = 1'b0;
    @(posedge clk);
    #1;
    while (got < 6 && cyc < 40) begin
      out_ready_i = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        in_valid_i = 1'b1;
        op_a_i     = 32'h3F800000 + 32'(sent) * 32'h0060_0000;
        unsigned_i = 1'(sent % 2);
        rm_i       = 3'(sent % 5);
        tag_i      = 5'(20 + sent);
      end else begin
        in_valid_i = 1'b0;
      end
      @(negedge clk);
      if (in_valid_i && !in_ready_o) saw_block = 1'b1;
      if (out_valid_o) begin
        if (expq.size() == 0) begin
          check("stream_extra", 64'd1, 64'd0);
        end else begin
          check("stream_res", 64'(result_o), 64'(expq[0][31:0]));
          check("stream_flg", 64'(fflags_o), 64'(expq[0][36:32]));
          check("stream_tag", 64'(tag_o), 64'(expq[0][41:37]));
          if (out_ready_i) begin
            void'(expq.pop_front());
            got++;
          end
        end
      end
      if (in_valid_i && in_ready_o) begin
        m = model(op_a_i, unsigned_i, rm_i);
        expq.push_back({tag_i, m});
        sent++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    check("stream_count", 64'(got), 64'd6);
    check("stream_blocked", 64'(saw_block), 64'd1);

    // Flush with both stages occupied; same-cycle input must be dropped
    @(posedge clk);
    #1 out_ready_i = 1'b0; in_valid_i = 1'b1; op_a_i = 32'h40400000; tag_i = 5'd1;
    @(posedge clk);
    #1 op_a_i = 32'h40800000; tag_i = 5'd2;
    @(posedge clk);
    #1 check("flush_full", 64'(in_ready_o), 64'd0);
    op_a_i = 32'h40A00000; tag_i = 5'd3; flush_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0; in_valid_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid_o) seen++;
      @(posedge clk);
      #1;
    end
    check("flush_no_out", 64'(seen), 64'd0);

    // Async reset while an op sits in the output stage
    @(negedge clk);
    op_a_i = 32'h40400000; rm_i = 3'd0; unsigned_i = 1'b0; tag_i = 5'd9; in_valid_i = 1'b1;
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    @(posedge clk);
    #1 check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    #2 reset_i = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_res", 64'(result_o), 64'd0);
    check("arst_tag", 64'(tag_o), 64'd0);
    check("arst_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk) reset_i = 1'b1;
    single(32'h3FC00000, 1'b0, 3'd0, 5'd30, 32'd2, 5'h01, "post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
